// File: rtl/fractal_sync_1d_local_ctrl.sv
// Request front-end for a 1D local synchronization register file: buffers two
// request ports, drives the RF id/check inputs and returns wake/error responses.
module fractal_sync_1d_local_ctrl #(
   parameter  int unsigned ID_WIDTH   = 1,
   parameter  int unsigned FIFO_DEPTH = 2,
   localparam int unsigned N_PORTS    = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [N_PORTS-1:0]               req_valid_i,
   output logic [N_PORTS-1:0]               req_ready_o,
   input  logic [N_PORTS-1:0][ID_WIDTH-1:0] req_id_i,
   output logic [N_PORTS-1:0]               rsp_valid_o,
   input  logic [N_PORTS-1:0]               rsp_ready_i,
   output logic [N_PORTS-1:0][ID_WIDTH-1:0] rsp_id_o,
   output logic [N_PORTS-1:0]               rsp_err_o,
   output logic [N_PORTS-1:0][ID_WIDTH-1:0] rf_id_o,
   output logic [N_PORTS-1:0]               rf_check_o,
   input  logic [N_PORTS-1:0]               rf_present_i,
   input  logic [N_PORTS-1:0]               rf_id_err_i,
   input  logic                             rf_bypass_i
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [ID_WIDTH-1:0]              fifo_mem [N_PORTS][FIFO_DEPTH];
   logic [N_PORTS-1:0][PTR_W-1:0]    wr_ptr;
   logic [N_PORTS-1:0][PTR_W-1:0]    rd_ptr;
   logic [N_PORTS-1:0][CNT_W-1:0]    count;
   logic [N_PORTS-1:0][ID_WIDTH-1:0] head;
   logic [N_PORTS-1:0]               empty;
   logic [N_PORTS-1:0]               full;
   logic [N_PORTS-1:0]               elig;
   logic [N_PORTS-1:0]               err;
   logic [N_PORTS-1:0]               wake;
   logic [N_PORTS-1:0]               resp;
   logic [N_PORTS-1:0]               hold;
   logic [N_PORTS-1:0]               pop;
   logic [N_PORTS-1:0]               push;
   logic [N_PORTS-1:0]               err_load;
   logic [N_PORTS-1:0]               rsp_valid;
   logic [N_PORTS-1:0]               rsp_err;
   logic [N_PORTS-1:0][ID_WIDTH-1:0] rsp_id;
   logic [ID_WIDTH-1:0]              wake_id;
   logic [ID_WIDTH-1:0]              id0;
   logic                             gate;
   logic                             byp;
   logic                             conflict;
   logic                             wake_load;
   logic                             rr_ptr;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
         nxt = PTR_W'(0);
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   // FIFO status and eligibility; any outstanding response closes the gate
   always_comb begin
      gate = ~rsp_valid[0] & ~rsp_valid[1];
      for (int p = 0; p < N_PORTS; p++) begin
         head[p]  = fifo_mem[p][rd_ptr[p]];
         empty[p] = (count[p] == CNT_W'(0));
         full[p]  = (count[p] == CNT_W'(FIFO_DEPTH));
         elig[p]  = ~empty[p] & gate;
      end
   end

   // RF id drive: an idle port mirrors the inverse of the other id so the RF
   // never sees a false bypass. A held port keeps its head id (check stays 0):
   // its classification must not feed back into the id the RF is looking at.
   always_comb begin
      if (elig[0]) begin
         id0 = head[0];
      end else if (elig[1]) begin
         id0 = ~head[1];
      end else begin
         id0 = {ID_WIDTH{1'b0}};
      end
      rf_id_o[0] = id0;
      if (elig[1]) begin
         rf_id_o[1] = head[1];
      end else begin
         rf_id_o[1] = ~id0;
      end
   end

   // Classification, wake/response conflict arbitration, pop/check/push
   always_comb begin
      err         = elig & rf_id_err_i;
      byp         = elig[0] & elig[1] & rf_bypass_i & ~err[0] & ~err[1];
      wake        = elig & ~err & {N_PORTS{~byp}} & rf_present_i;
      resp        = err | wake;
      conflict    = (wake[0] & resp[1]) | (wake[1] & resp[0]);
      hold[0]     = conflict & rr_ptr;
      hold[1]     = conflict & ~rr_ptr;
      pop         = elig & ~hold;
      rf_check_o  = pop & ~err;
      req_ready_o = ~full | pop;
      push        = req_valid_i & req_ready_o;
      err_load    = err & ~hold;
      wake_load   = byp | (|(wake & ~hold));
      if (wake[0] & ~hold[0]) begin
         wake_id = head[0];
      end else begin
         wake_id = head[1];
      end
   end

   // Per-port request FIFO storage and pointers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int p = 0; p < N_PORTS; p++) begin
            wr_ptr[p] <= PTR_W'(0);
            rd_ptr[p] <= PTR_W'(0);
            count[p]  <= CNT_W'(0);
            for (int e = 0; e < FIFO_DEPTH; e++) begin
               fifo_mem[p][e] <= {ID_WIDTH{1'b0}};
            end
         end
      end else begin
         for (int p = 0; p < N_PORTS; p++) begin
            if (push[p]) begin
               fifo_mem[p][wr_ptr[p]] <= req_id_i[p];
               wr_ptr[p]              <= ptr_next(wr_ptr[p]);
            end
            if (pop[p]) begin
               rd_ptr[p] <= ptr_next(rd_ptr[p]);
            end
            if (push[p] & ~pop[p]) begin
               count[p] <= count[p] + CNT_W'(1);
            end else if (~push[p] & pop[p]) begin
               count[p] <= count[p] - CNT_W'(1);
            end
         end
      end
   end

   // Response slots and round-robin pointer; a wake always fills both slots
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid <= {N_PORTS{1'b0}};
         rsp_err   <= {N_PORTS{1'b0}};
         rsp_id    <= {(N_PORTS*ID_WIDTH){1'b0}};
         rr_ptr    <= 1'b0;
      end else begin
         if (conflict) begin
            rr_ptr <= ~rr_ptr;
         end
         for (int p = 0; p < N_PORTS; p++) begin
            if (wake_load) begin
               rsp_valid[p] <= 1'b1;
               rsp_id[p]    <= wake_id;
               rsp_err[p]   <= 1'b0;
            end else if (err_load[p]) begin
               rsp_valid[p] <= 1'b1;
               rsp_id[p]    <= head[p];
               rsp_err[p]   <= 1'b1;
            end else if (rsp_valid[p] & rsp_ready_i[p]) begin
               rsp_valid[p] <= 1'b0;
            end
         end
      end
   end

   assign rsp_valid_o = rsp_valid;
   assign rsp_id_o    = rsp_id;
   assign rsp_err_o   = rsp_err;

endmodule

// File: tb/tb_fractal_sync_1d_local_ctrl.sv
// Bench for fractal_sync_1d_local_ctrl: behavioural RF, queue-based reference
// model, a directed vector table, corner-case sequences and random traffic.
module tb_fractal_sync_1d_local_ctrl;
   localparam int IDW   = 1;
   localparam int DEPTH = 2;
   localparam int NID   = 1 << IDW;
   typedef logic [IDW-1:0] id_t;

   logic                clk;
   logic                rst_n;
   logic [1:0]          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic [1:0]          rf_check, rf_present, rf_id_err;
   logic [1:0][IDW-1:0] req_id, rsp_id, rf_id;
   logic                rf_bypass;
   logic [NID-1:0]      rf_bits, err_mask, preset_val;
   logic                preset_en;

   int n_checks = 0;
   int n_fail   = 0;

   fractal_sync_1d_local_ctrl #(.ID_WIDTH(IDW), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_id_i     (req_id),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_id_o     (rsp_id),
      .rsp_err_o    (rsp_err),
      .rf_id_o      (rf_id),
      .rf_check_o   (rf_check),
      .rf_present_i (rf_present),
      .rf_id_err_i  (rf_id_err),
      .rf_bypass_i  (rf_bypass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RF: bit per id, id errors from a mask, bypass on equal ids
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rf_present[p] = rf_bits[rf_id[p]];
         rf_id_err[p]  = err_mask[rf_id[p]];
      end
      rf_bypass = (rf_id[0] == rf_id[1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_bits <= '0;
      end else if (preset_en) begin
         rf_bits <= preset_val;
      end else if (!(rf_bypass && rf_check[0] && rf_check[1])) begin
         for (int p = 0; p < 2; p++) begin
            if (rf_check[p]) rf_bits[rf_id[p]] <= ~rf_bits[rf_id[p]];
         end
      end
   end

   // Reference model state: request queues, response slots, RF bits, pointer
   id_t            mq [2][$];
   logic [1:0]     mv, me;
   id_t            mid [2];
   logic           mptr;
   logic [NID-1:0] mbits;
   logic [1:0]     x_pop, x_chk, x_ready, x_err_ld, x_el;
   logic [NID-1:0] x_set, x_clr;
   logic           x_wake, x_clash;
   id_t            x_wake_id;
   id_t            x_head [2];

   typedef struct {
      logic [1:0] vld;
      logic [1:0] id;
      logic [1:0] rv;
      logic [1:0] rid;
      logic [1:0] chk;
      logic [1:0] bits;
   } row_t;
   row_t rows [11];
   bit   row_on;
   int   cur_row;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq[0].delete();
      mq[1].delete();
      mv    = 2'b00;
      me    = 2'b00;
      mid[0] = '0;
      mid[1] = '0;
      mptr  = 1'b0;
      mbits = '0;
   endtask

   // Apply the classification rules to the current queue heads and inputs
   task automatic model_eval();
      int  kind [2];
      bit  gate;
      gate = !mv[0] && !mv[1];
      x_pop = 2'b00; x_chk = 2'b00; x_err_ld = 2'b00; x_el = 2'b00;
      x_set = '0; x_clr = '0; x_wake = 1'b0; x_wake_id = '0; x_clash = 1'b0;
      for (int p = 0; p < 2; p++) begin
         kind[p]   = 0;
         x_el[p]   = gate && (mq[p].size() > 0);
         x_head[p] = (mq[p].size() > 0) ? mq[p][0] : '0;
      end
      if (x_el[0] && x_el[1] && x_head[0] == x_head[1] && !err_mask[x_head[0]]) begin
         x_pop = 2'b11; x_chk = 2'b11; x_wake = 1'b1; x_wake_id = x_head[0];
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (x_el[p]) kind[p] = err_mask[x_head[p]] ? 1 : (mbits[x_head[p]] ? 2 : 3);
         end
         x_clash = (kind[0] == 2 && (kind[1] == 1 || kind[1] == 2)) ||
                   (kind[1] == 2 && (kind[0] == 1 || kind[0] == 2));
         if (x_clash) kind[mptr ? 0 : 1] = 0;
         for (int p = 0; p < 2; p++) begin
            if (kind[p] != 0) x_pop[p] = 1'b1;
            if (kind[p] >= 2) x_chk[p] = 1'b1;
            if (kind[p] == 1) x_err_ld[p] = 1'b1;
            if (kind[p] == 2) begin x_wake = 1'b1; x_wake_id = x_head[p]; x_clr[x_head[p]] = 1'b1; end
            if (kind[p] == 3) x_set[x_head[p]] = 1'b1;
         end
      end
      for (int p = 0; p < 2; p++) x_ready[p] = (mq[p].size() < DEPTH) || x_pop[p];
   endtask

   task automatic model_commit();
      for (int p = 0; p < 2; p++) begin
         if (x_pop[p]) void'(mq[p].pop_front());
         if (req_valid[p] && x_ready[p]) mq[p].push_back(req_id[p]);
         if (x_wake) begin
            mv[p] = 1'b1; mid[p] = x_wake_id; me[p] = 1'b0;
         end else if (x_err_ld[p]) begin
            mv[p] = 1'b1; mid[p] = x_head[p]; me[p] = 1'b1;
         end else if (mv[p] && rsp_ready[p]) begin
            mv[p] = 1'b0;
         end
      end
      if (preset_en) mbits = preset_val;
      else mbits = (mbits | x_set) & ~x_clr;
      if (x_clash) mptr = !mptr;
   endtask

   task automatic compare_model();
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("rsp_valid[%0d]", p), rsp_valid[p], mv[p]);
         if (mv[p]) begin
            chk($sformatf("rsp_id[%0d]", p), rsp_id[p], mid[p]);
            chk($sformatf("rsp_err[%0d]", p), rsp_err[p], me[p]);
         end
         chk($sformatf("req_ready[%0d]", p), req_ready[p], x_ready[p]);
         chk($sformatf("rf_check[%0d]", p), rf_check[p], x_chk[p]);
         if (x_el[p]) chk($sformatf("rf_id[%0d]", p), rf_id[p], x_head[p]);
      end
      chk("rf_bits", rf_bits, mbits);
   endtask

   task automatic compare_row();
      chk($sformatf("tbl%0d_rsp_valid", cur_row), rsp_valid, rows[cur_row].rv);
      chk($sformatf("tbl%0d_req_ready", cur_row), req_ready, 2'b11);
      chk($sformatf("tbl%0d_rf_check", cur_row), rf_check, rows[cur_row].chk);
      chk($sformatf("tbl%0d_rf_bits", cur_row), rf_bits, rows[cur_row].bits);
      for (int p = 0; p < 2; p++) begin
         if (rows[cur_row].rv[p]) begin
            chk($sformatf("tbl%0d_rsp_id[%0d]", cur_row, p), rsp_id[p], rows[cur_row].rid[p]);
            chk($sformatf("tbl%0d_rsp_err[%0d]", cur_row, p), rsp_err[p], 1'b0);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_eval();
      compare_model();
      if (row_on) compare_row();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic preset(input logic [NID-1:0] val);
      preset_val = val;
      preset_en  = 1'b1;
      step();
      preset_en  = 1'b0;
   endtask

   task automatic idle(input int n);
      req_valid = 2'b00;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      //          vld    id     rv     rid    chk    bits
      rows[0]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
      rows[1]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
      rows[2]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
      rows[3]  = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
      rows[4]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
      rows[5]  = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
      rows[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      rows[7]  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      rows[8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
      rows[9]  = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
      rows[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

      rst_n = 1'b0; req_valid = 2'b00; req_id = '0; rsp_ready = 2'b11;
      err_mask = '0; preset_en = 1'b0; preset_val = '0; row_on = 1'b0; cur_row = 0;
      model_reset();
      #8;
      chk("reset_rsp_valid", rsp_valid, 2'b00);
      chk("reset_rsp_id", rsp_id, 2'b00);
      chk("reset_rsp_err", rsp_err, 2'b00);
      chk("reset_req_ready", req_ready, 2'b11);
      chk("reset_rf_check", rf_check, 2'b00);
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors: wake after partner, then same-cycle bypass
      row_on = 1'b1;
      for (int i = 0; i < 11; i++) begin
         cur_row   = i;
         req_valid = rows[i].vld;
         req_id    = rows[i].id;
         step();
      end
      row_on = 1'b0;

      // Id error on port 1 only
      err_mask = 2'b10;
      req_valid = 2'b10; req_id = 2'b10;
      step();
      idle(1);
      chk("err_rsp_valid", rsp_valid, 2'b10);
      chk("err_rsp_err", rsp_err[1], 1'b1);
      chk("err_rsp_id", rsp_id[1], 1'b1);
      idle(2);
      err_mask = '0;

      // Conflict: both present, pointer 0 serves port 0 first, then port 1
      preset(2'b11);
      req_valid = 2'b11; req_id = 2'b10;
      step();
      idle(1);
      chk("rr0_first_valid", rsp_valid, 2'b11);
      chk("rr0_first_id", rsp_id, 2'b00);
      idle(2);
      chk("rr0_second_id", rsp_id, 2'b11);
      idle(1);
      preset(2'b11);
      req_valid = 2'b11; req_id = 2'b10;
      step();
      idle(1);
      chk("rr1_first_id", rsp_id, 2'b11);
      idle(2);
      chk("rr1_second_id", rsp_id, 2'b00);
      idle(2);

      // Port 0 response stalled: no processing, FIFOs fill, ready drops
      rsp_ready = 2'b10;
      req_valid = 2'b11; req_id = 2'b11;
      step();
      idle(1);
      for (int i = 0; i < 10; i++) begin
         req_valid = 2'b11;
         req_id    = 2'($urandom);
         step();
         chk("stall_rsp_id0", rsp_id[0], 1'b1);
      end
      chk("stall_ready", req_ready, 2'b00);
      chk("stall_rsp_valid", rsp_valid, 2'b01);
      rsp_ready = 2'b11;
      idle(20);

      // Asynchronous reset with queued requests and pending responses
      rsp_ready = 2'b00;
      req_valid = 2'b11; req_id = 2'b00;
      step();
      req_valid = 2'b01; req_id = 2'b01;
      step();
      step();
      req_valid = 2'b00;
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 2'b00);
      chk("midrst_req_ready", req_ready, 2'b11);
      chk("midrst_rsp_id", rsp_id, 2'b00);
      chk("midrst_rf_check", rf_check, 2'b00);
      model_reset();
      @(posedge clk);
      #3 rst_n = 1'b1;
      rsp_ready = 2'b11;
      idle(4);

      // Random traffic against the reference model
      for (int c = 0; c < 1500; c++) begin
         if (c % 250 == 0) err_mask = ($urandom_range(0, 2) == 0) ? NID'($urandom) : '0;
         for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'($urandom_range(0, 1));
            req_id[p]    = id_t'($urandom);
            rsp_ready[p] = ($urandom_range(0, 3) != 0);
         end
         step();
      end
      err_mask  = '0;
      rsp_ready = 2'b11;
      idle(20);
      chk("drain_ready", req_ready, 2'b11);
      chk("drain_rsp_valid", rsp_valid, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
